// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: receive-side monitor for a 4-digit multiplexed, active-low
// seven-segment scan. Rebuilds the BCD value being shown and publishes
// complete frames with validity, change and error flags.
//
// Optional build macro: SEG_DEC_CONFIRM_EN. When defined, a frame is only
// published after two consecutive identical, error-free frames.
module seg_scan_decoder #(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  sel,
  input  logic [6:0]  seg,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        data_changed,
  output logic        frame_err,
  output logic        scan_lost
);

  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYC);
  localparam logic [19:0] TO_LIM     = 20'(TIMEOUT_CYC);

  // {legal, position[1:0]} for an active-low one-hot digit select
  function automatic logic [2:0] sel_decode(input logic [3:0] s);
    case (s)
      4'b1110: sel_decode = 3'b100;
      4'b1101: sel_decode = 3'b101;
      4'b1011: sel_decode = 3'b110;
      4'b0111: sel_decode = 3'b111;
      default: sel_decode = 3'b000;
    endcase
  endfunction

  // {undecodable, digit[3:0]} for active-low {g,f,e,d,c,b,a}
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = 5'h00;
      7'b1111001: seg_decode = 5'h01;
      7'b0100100: seg_decode = 5'h02;
      7'b0110000: seg_decode = 5'h03;
      7'b0011001: seg_decode = 5'h04;
      7'b0010010: seg_decode = 5'h05;
      7'b0000010: seg_decode = 5'h06;
      7'b1111000: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0010000: seg_decode = 5'h09;
      default:    seg_decode = 5'h1F;
    endcase
  endfunction

  // Registered inputs and history
  logic [3:0]  sel_q, sel_prev_q;
  logic [6:0]  seg_q;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [19:0] to_cnt_q, to_cnt_d;

  // Frame assembly
  logic [15:0] frame_q, frame_d;
  logic [3:0]  mask_q, mask_d;
  logic        err_q, err_d;

  // Published outputs
  logic [15:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        data_changed_q, data_changed_d;
  logic        frame_err_q, frame_err_d;
  logic        scan_lost_q, scan_lost_d;

`ifdef SEG_DEC_CONFIRM_EN
  logic [15:0] cand_q, cand_d;
  logic        cand_vld_q, cand_vld_d;
  logic        cand_err_q, cand_err_d;
`endif

  logic        sel_chg;
  logic        sel_legal;
  logic [1:0]  sel_idx;
  logic        seg_bad;
  logic [3:0]  seg_dig;
  logic        strobe;
  logic        pub_rdy;
  logic        to_expire;

  assign sel_chg              = (sel_q != sel_prev_q);
  assign {sel_legal, sel_idx} = sel_decode(sel_q);
  assign {seg_bad, seg_dig}   = seg_decode(seg_q);
  // Fires once per dwell, on the last counting step before saturation
  assign strobe    = sel_legal && !sel_chg && (stab_cnt_q == SETTLE_LIM - 8'd1);
  assign pub_rdy   = (mask_q == 4'b1111);
  assign to_expire = !sel_chg && (to_cnt_d == TO_LIM);

  // Next-state logic: settle/timeout counters, frame capture and publish
  always_comb begin
    stab_cnt_d     = stab_cnt_q;
    to_cnt_d       = to_cnt_q;
    frame_d        = frame_q;
    mask_d         = mask_q;
    err_d          = err_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    data_changed_d = 1'b0;
    frame_err_d    = frame_err_q;
    scan_lost_d    = scan_lost_q;
`ifdef SEG_DEC_CONFIRM_EN
    cand_d         = cand_q;
    cand_vld_d     = cand_vld_q;
    cand_err_d     = cand_err_q;
`endif

    if (sel_chg || !sel_legal) begin
      stab_cnt_d = 8'd0;
    end else if (stab_cnt_q < SETTLE_LIM) begin
      stab_cnt_d = stab_cnt_q + 8'd1;
    end

    if (sel_chg) begin
      to_cnt_d = 20'd0;
    end else if (to_cnt_q != TO_LIM) begin
      to_cnt_d = to_cnt_q + 20'd1;
    end

    // Publish the completed frame and start a fresh one
    if (pub_rdy) begin
      mask_d = 4'b0000;
      err_d  = 1'b0;
`ifdef SEG_DEC_CONFIRM_EN
      if (cand_vld_q && !cand_err_q && !err_q && (frame_q == cand_q)) begin
        data_out_d     = frame_q;
        data_valid_d   = 1'b1;
        data_changed_d = (frame_q != data_out_q);
        frame_err_d    = 1'b0;
      end
      cand_d     = frame_q;
      cand_vld_d = 1'b1;
      cand_err_d = err_q;
`else
      data_out_d     = frame_q;
      data_valid_d   = 1'b1;
      data_changed_d = (frame_q != data_out_q);
      frame_err_d    = err_q;
`endif
    end

    // A capture in the publish cycle belongs to the new frame
    if (strobe) begin
      frame_d[{sel_idx, 2'b00} +: 4] = seg_dig;
      mask_d[sel_idx]                = 1'b1;
      if (seg_bad) begin
        err_d = 1'b1;
      end
    end

    // Lost scan abandons the partial frame; published data is kept
    if (sel_chg) begin
      scan_lost_d = 1'b0;
    end else if (to_expire) begin
      scan_lost_d = 1'b1;
      mask_d      = 4'b0000;
      err_d       = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q          <= 4'b1111;
      sel_prev_q     <= 4'b1111;
      seg_q          <= 7'b1111111;
      stab_cnt_q     <= 8'd0;
      to_cnt_q       <= 20'd0;
      frame_q        <= 16'h0000;
      mask_q         <= 4'b0000;
      err_q          <= 1'b0;
      data_out_q     <= 16'h0000;
      data_valid_q   <= 1'b0;
      data_changed_q <= 1'b0;
      frame_err_q    <= 1'b0;
      scan_lost_q    <= 1'b0;
`ifdef SEG_DEC_CONFIRM_EN
      cand_q         <= 16'h0000;
      cand_vld_q     <= 1'b0;
      cand_err_q     <= 1'b0;
`endif
    end else begin
      sel_q          <= sel;
      sel_prev_q     <= sel_q;
      seg_q          <= seg;
      stab_cnt_q     <= stab_cnt_d;
      to_cnt_q       <= to_cnt_d;
      frame_q        <= frame_d;
      mask_q         <= mask_d;
      err_q          <= err_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      data_changed_q <= data_changed_d;
      frame_err_q    <= frame_err_d;
      scan_lost_q    <= scan_lost_d;
`ifdef SEG_DEC_CONFIRM_EN
      cand_q         <= cand_d;
      cand_vld_q     <= cand_vld_d;
      cand_err_q     <= cand_err_d;
`endif
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign data_changed = data_changed_q;
  assign frame_err    = frame_err_q;
  assign scan_lost    = scan_lost_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (default build, confirm mode off).
module tb_seg_scan_decoder;

  localparam int S  = 4;
  localparam int TO = 1000;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sel   = 4'b1111;
  logic [6:0]  seg   = 7'b1111111;
  logic [15:0] data_out;
  logic        data_valid, data_changed, frame_err, scan_lost;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int dv_cnt   = 0;
  int dv_cyc   = 0;
  int t3       = 0;
  int t_freeze = 0;
  logic [15:0] dv_data = 16'h0;
  logic        dv_chg  = 1'b0;
  logic        dv_err  = 1'b0;

  seg_scan_decoder #(.SETTLE_CYC(S), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel),
    .seg          (seg),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .data_changed (data_changed),
    .frame_err    (frame_err),
    .scan_lost    (scan_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every publish pulse and what accompanied it
  always @(negedge clk) begin
    if (data_valid) begin
      dv_cnt  <= dv_cnt + 1;
      dv_cyc  <= cyc;
      dv_data <= data_out;
      dv_chg  <= data_changed;
      dv_err  <= frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] sel_of(input int d);
    case (d)
      0:       sel_of = 4'b1110;
      1:       sel_of = 4'b1101;
      2:       sel_of = 4'b1011;
      default: sel_of = 4'b0111;
    endcase
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = 7'b1111111;
    endcase
  endfunction

  // Called at a negedge; holds the pattern for n sampling edges
  task automatic dwell(input logic [3:0] s, input logic [6:0] g, input int n);
    sel = s;
    seg = g;
    repeat (n) @(negedge clk);
  endtask

  task automatic show_digit(input logic [15:0] v, input int d, input int n);
    if (d == 3) t3 = cyc;
    dwell(sel_of(d), seg_of(v[d*4 +: 4]), n);
  endtask

  task automatic show_frame(input logic [15:0] v, input int n);
    for (int d = 0; d < 4; d++) show_digit(v, d, n);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset data_out",     32'(data_out),     32'h0);
    check("reset data_valid",   32'(data_valid),   32'h0);
    check("reset data_changed", 32'(data_changed), 32'h0);
    check("reset frame_err",    32'(frame_err),    32'h0);
    check("reset scan_lost",    32'(scan_lost),    32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame: the first sampling edge of digit3 is cyc t3+1; publish
    // is visible SETTLE_CYC+2 edges after that.
    show_frame(16'h1234, 10);
    check("basic count",   32'(dv_cnt),  32'd1);
    check("basic latency", 32'(dv_cyc),  32'(t3 + S + 3));
    check("basic data",    32'(dv_data), 32'h1234);
    check("basic changed", 32'(dv_chg),  32'h1);
    check("basic err",     32'(dv_err),  32'h0);

    // Repeated frames publish again without a change flag
    for (int r = 0; r < 2; r++) begin
      show_frame(16'h1234, 10);
      check("repeat count",   32'(dv_cnt),  32'(2 + r));
      check("repeat data",    32'(dv_data), 32'h1234);
      check("repeat changed", 32'(dv_chg),  32'h0);
    end

    // Short dwells and illegal selects capture nothing
    show_frame(16'h5678, 3);
    dwell(4'b1111, seg_of(4'd8), 20);
    dwell(4'b0011, seg_of(4'd8), 20);
    check("short no valid", 32'(dv_cnt),   32'd3);
    check("short data hold", 32'(data_out), 32'h1234);
    for (int d = 0; d < 3; d++) show_digit(16'h5678, d, 10);
    check("short mask empty", 32'(dv_cnt), 32'd3);
    show_digit(16'h5678, 3, 10);
    check("short then full count", 32'(dv_cnt),  32'd4);
    check("short then full data",  32'(dv_data), 32'h5678);
    check("short then full chg",   32'(dv_chg),  32'h1);

    // Blank digit2 decodes to F and flags the frame
    show_frame(16'h9F99, 10);
    check("blank count", 32'(dv_cnt),  32'd5);
    check("blank data",  32'(dv_data), 32'h9F99);
    check("blank err",   32'(dv_err),  32'h1);
    repeat (5) @(negedge clk);
    check("blank err held", 32'(frame_err), 32'h1);
    show_frame(16'h1234, 10);
    check("after blank count", 32'(dv_cnt),  32'd6);
    check("after blank err",   32'(dv_err),  32'h0);
    check("after blank data",  32'(dv_data), 32'h1234);

    // Timeout: freeze on digit1 after capturing digits 0 and 1
    show_digit(16'h4321, 0, 10);
    t_freeze = cyc;
    sel = sel_of(1);
    seg = seg_of(4'd2);
    repeat (995) @(negedge clk);
    check("timeout early", 32'(scan_lost), 32'h0);
    repeat (15) @(negedge clk);
    check("timeout set",   32'(scan_lost), 32'h1);
    check("timeout hold",  32'(data_out),  32'h1234);
    check("timeout elapsed", 32'(cyc - t_freeze), 32'd1010);
    show_digit(16'h4321, 2, 10);
    check("resume clears lost", 32'(scan_lost), 32'h0);
    show_digit(16'h4321, 3, 10);
    check("resume needs 4", 32'(dv_cnt), 32'd6);
    show_digit(16'h4321, 0, 10);
    show_digit(16'h4321, 1, 10);
    check("resume count", 32'(dv_cnt),  32'd7);
    check("resume data",  32'(dv_data), 32'h4321);

    // Reset after two captures
    show_digit(16'h8765, 0, 10);
    show_digit(16'h8765, 1, 10);
    #2 rst_n = 1'b0;
    #1;
    check("midrst data_out",  32'(data_out),     32'h0);
    check("midrst valid",     32'(data_valid),   32'h0);
    check("midrst changed",   32'(data_changed), 32'h0);
    check("midrst err",       32'(frame_err),    32'h0);
    check("midrst lost",      32'(scan_lost),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    show_digit(16'h8765, 2, 10);
    show_digit(16'h8765, 3, 10);
    check("midrst mask cleared", 32'(dv_cnt), 32'd7);
    show_digit(16'h8765, 0, 10);
    show_digit(16'h8765, 1, 10);
    check("midrst count",   32'(dv_cnt),  32'd8);
    check("midrst data",    32'(dv_data), 32'h8765);
    check("midrst chg",     32'(dv_chg),  32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
